// File: rtl/lockstep_pkg.sv
// Shared state encoding for the lockstep compare controller.
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    FAULT  = 2'd3
  } lockstep_state_t;

  // Plain constants for the state register and the state output port.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WARMUP = WARMUP;
  localparam logic [1:0] ST_CHECK  = CHECK;
  localparam logic [1:0] ST_FAULT  = FAULT;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear beats increment, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  // Next count: clear first, otherwise count up until all-ones.
  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else if (inc && (q_reg != '1)) begin
      q_next = q_reg + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/lockstep_compare_ctrl.sv
// Supervises a bank of delay-compare channels: holds them in reset while idle,
// masks results for the pipeline fill, then flags persistent mismatches with a
// sticky, acknowledgeable fault and a capture of the offending channels.
module lockstep_compare_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int DELAY    = 3,
  parameter int CNT_W    = 16,
  parameter int THRESH_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [NUM_CH-1:0]   equal,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                fault_ack,
  input  logic                cnt_clr,
  output logic                comp_rst,
  output logic [1:0]          state,
  output logic                checking,
  output logic                fault,
  output logic [NUM_CH-1:0]   fault_ch,
  output logic [CNT_W-1:0]    mismatch_cnt
);

  import lockstep_pkg::*;

  localparam int WARM_W = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(DELAY - 1);

  logic [1:0]          state_reg, state_next;
  logic [WARM_W-1:0]   warm_reg, warm_next;
  logic                fault_reg, fault_next;
  logic [NUM_CH-1:0]   fault_ch_reg, fault_ch_next;

  logic [THRESH_W-1:0] consec;
  logic [NUM_CH-1:0]   mism_vec;
  logic                in_idle, in_check, in_fault;
  logic                mism;
  logic [THRESH_W:0]   consec_plus1;
  logic [THRESH_W:0]   thr_eff;
  logic                trip;
  logic                consec_clr;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_check = (state_reg == ST_CHECK);
  assign in_fault = (state_reg == ST_FAULT);

  // Only participating channels can mismatch, and only while checking.
  assign mism_vec = ~equal & ch_mask;
  assign mism     = in_check && (|mism_vec);

  // One extra bit so the compare works even when consec is at its ceiling.
  assign consec_plus1 = {1'b0, consec} + (THRESH_W + 1)'(1);
  assign thr_eff      = (threshold == '0) ? (THRESH_W + 1)'(1) : {1'b0, threshold};
  assign trip         = mism && (consec_plus1 >= thr_eff);

  // A matching cycle breaks the run; a fresh session and an ack start from zero.
  assign consec_clr = in_idle || (in_check && !(|mism_vec)) || (in_fault && fault_ack);

  sat_counter #(.W(THRESH_W)) u_consec (
    .clk (clk),
    .rst (rst),
    .inc (mism),
    .clr (consec_clr),
    .q   (consec)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mism),
    .clr (cnt_clr),
    .q   (mismatch_cnt)
  );

  // Next-state logic; fault detection takes priority over leaving CHECK.
  always_comb begin
    state_next    = state_reg;
    warm_next     = warm_reg;
    fault_next    = fault_reg;
    fault_ch_next = fault_ch_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_WARMUP;
          warm_next  = WARM_LOAD;
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (warm_reg == '0) begin
          state_next = ST_CHECK;
        end else begin
          warm_next = warm_reg - WARM_W'(1);
        end
      end
      ST_CHECK: begin
        if (trip) begin
          state_next    = ST_FAULT;
          fault_next    = 1'b1;
          fault_ch_next = mism_vec;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_ack) begin
          state_next    = ST_IDLE;
          fault_next    = 1'b0;
          fault_ch_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, warm-up count and fault capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      warm_reg     <= '0;
      fault_reg    <= 1'b0;
      fault_ch_reg <= '0;
    end else begin
      state_reg    <= state_next;
      warm_reg     <= warm_next;
      fault_reg    <= fault_next;
      fault_ch_reg <= fault_ch_next;
    end
  end

  assign state    = state_reg;
  assign comp_rst = in_idle;
  assign checking = in_check;
  assign fault    = fault_reg;
  assign fault_ch = fault_ch_reg;

endmodule
